ysyx_040066_mem_arbiter: RTL and testbench
==========================================

# ysyx_040066_mem_arbiter

Two-master arbiter that shares the single cache-line memory port between the I-cache and the D-cache. It sits between both cache controllers' line-refill/writeback interfaces and the AXI bridge. It grants one whole transaction at a time: a read burst up to and including `rd_last`, or a single-handshake line write. Arbitration is round-robin, with a pairing rule that keeps a D-cache dirty eviction and its refill back-to-back.

## Interface
Parameters:
- `LINE_LEN`, 512, width of a cache line carried by a write.
- `ADDR_LEN`, 32, width of the line address.

Ports (`x` ∈ {`i`, `d`}; the master ports are identical for both caches):
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, asynchronous, active-low; asserted when 0.
- `x_addr`  in  ADDR_LEN  line address from cache x.
- `x_rd_req`  in  1  read-burst request; held by the cache until its `rd_last` handshake.
- `x_wr_req`  in  1  line-write request; held by the cache until `wr_ready`.
- `x_wr_data`  in  LINE_LEN  line to write.
- `x_rd_ready`  out  1  read beat valid for cache x.
- `x_rd_last`  out  1  final beat of the burst.
- `x_rd_data`  out  64  read beat data.
- `x_rd_error`  out  1  read error.
- `x_wr_ready`  out  1  write accepted.
- `x_wr_error`  out  1  write error.
- `mem_addr`  out  ADDR_LEN  downstream address.
- `mem_rd_req`  out  1  downstream read request.
- `mem_wr_req`  out  1  downstream write request.
- `mem_wr_data`  out  LINE_LEN  downstream write line.
- `mem_rd_ready`, `mem_rd_last`, `mem_rd_error`  in  1 each  downstream read handshake signals.
- `mem_rd_data`  in  64  downstream read beat.
- `mem_wr_ready`, `mem_wr_error`  in  1 each  downstream write handshake signals.

## Operation
State machine states: `IDLE`, `RD` and `WR`. Registers: `owner` (0 = I, 1 = D), `last_owner`, `pair_valid`, `pair_owner`.

- **IDLE**
  - A master is requesting if `rd_req | wr_req`.
  - No requester: remain in `IDLE`.
  - One requester: grant it.
  - Both requesting and `pair_valid`: grant `pair_owner`.
  - Both requesting otherwise: grant `~last_owner`.
  - On a grant: set `owner` and `last_owner`, clear `pair_valid`, and go to `WR` if the winner's `wr_req` is high, else `RD`. Write wins when a master raises both.
- **RD**
  - Outputs are combinational from the owner: `mem_addr`, `mem_rd_req` = owner `rd_req`, `mem_wr_req` = 0.
  - The owner's `rd_ready`, `rd_last`, `rd_data` and `rd_error` pass through in the same cycle.
  - On `mem_rd_ready & mem_rd_last`: go to `IDLE`.
- **WR**
  - Outputs: `mem_wr_req` = owner `wr_req`, `mem_wr_data` = owner `wr_data`, `mem_rd_req` = 0.
  - The owner's `wr_ready` and `wr_error` pass through.
  - On `mem_wr_ready`: go to `IDLE`, set `pair_valid` = 1 and `pair_owner` = owner, so the refill that follows an eviction wins the next tie.
- **Non-owner and IDLE outputs**
  - Every `x_*` ready, last and error output is 0.
  - `x_rd_data` is `mem_rd_data` unconditionally; it is qualified by ready.
- **Request drop.** The owner dropping its request mid-grant is illegal. The block stays in its state and `mem_*_req` follows the input.
- **Reset.** `rst` = 0 forces `IDLE`, `owner` = 0, `last_owner` = 0 (so D wins the first tie), and `pair_valid` = 0.
  - All outputs are 0 while in reset: `mem_rd_req`, `mem_wr_req`, `mem_addr`, `mem_wr_data` and every `x_*` output.
  - Reset asserted mid-burst drops `mem_rd_req` immediately. Remaining beats are ignored and are not forwarded.

## Timing
- **Grant latency.** Request first seen in `IDLE` at cycle N; `mem_*_req` is high at cycle N+1.
- **Response path.** Responses are zero-latency combinational pass-through; there is no buffering.
- **Return to IDLE.** The cycle after the completing handshake (`rd_last` beat or `wr_ready`) is always `IDLE`. That gives a minimum of one bubble between transactions.
- **Eviction-refill pairing.** A D-cache write completes at cycle N, D raises `rd_req` at cycle N+1 and wins even against a pending I request. `mem_rd_req` for D is high at cycle N+2.
- **Pair expiry.** `pair_valid` lives for exactly one `IDLE` decision. It is cleared on the next grant whoever wins.

## Test plan
- **Single read burst.** I requests alone at cycle 0 and memory returns 8 beats from cycle 3, `rd_last` on the 8th. Required: `mem_rd_req` = 1 at cycle 1, `mem_addr` = `i_addr`, and all 8 beats forwarded the same cycle to `i_*`. `IDLE` the cycle after the last beat, and `d_rd_ready` = 0 throughout.
- **Tie after reset.** Both masters raise `rd_req` at cycle 0 after reset. Required: D is granted first (cycle 1); I is granted one cycle after D's `rd_last`. A second tie then goes to D again (alternation).
- **Eviction pairing.** D raises `wr_req` (`addr` = 0x8000_1000) while I is idle. After `mem_wr_ready`, I and D both request. Required: D's read (`addr` = 0x8000_2000) is granted before I, and `pair_valid` = 0 afterwards.
- **Isolation.** D owns a burst while I holds `rd_req`. Required: `i_rd_ready` stays 0 during every `mem_rd_ready` beat; `mem_wr_req` = 0 in `RD`.
- **Errors.** `mem_wr_error` = 1 with `mem_wr_ready` on a D write gives `d_wr_error` = 1 and `i_wr_error` = 0. `mem_rd_error` on an I beat reaches only `i_rd_error`.
- **Reset mid-burst.** `rst` = 0 at beat 4 of 8. Required: `mem_rd_req` = 0 the same cycle, the state is `IDLE`, and there are no beats to any master. After release, a new tie grants D.

Source files
------------

// File: rtl/ysyx_040066_mem_arbiter_if.sv
// Cache-line memory port: a requester (master) issues line addresses,
// read-burst and line-write requests; the responder (slave) returns beats
// and write acknowledgements.
interface ysyx_040066_mem_arbiter_if #(
  parameter int LINE_LEN = 512,
  parameter int ADDR_LEN = 32
);
  logic [ADDR_LEN-1:0] addr;
  logic                rd_req;
  logic                wr_req;
  logic [LINE_LEN-1:0] wr_data;
  logic                rd_ready;
  logic                rd_last;
  logic [63:0]         rd_data;
  logic                rd_error;
  logic                wr_ready;
  logic                wr_error;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  rd_ready, rd_last, rd_data, rd_error, wr_ready, wr_error
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output rd_ready, rd_last, rd_data, rd_error, wr_ready, wr_error
  );
endinterface

// File: rtl/ysyx_040066_mem_arbiter.sv
// Two-master arbiter sharing one cache-line memory port between the I-cache
// (index 0) and the D-cache (index 1). One whole transaction is granted at a
// time; ties go round-robin, except that the master whose line write just
// completed wins the next tie so an eviction is followed by its refill.
module ysyx_040066_mem_arbiter #(
  parameter int LINE_LEN = 512,
  parameter int ADDR_LEN = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ysyx_040066_mem_arbiter_if.slave  i_port,
  ysyx_040066_mem_arbiter_if.slave  d_port,
  ysyx_040066_mem_arbiter_if.master mem_port
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   pair_valid_q, pair_valid_d;
  logic   pair_owner_q, pair_owner_d;

  // Masters gathered into index-addressable form: bit/entry 0 = I, 1 = D.
  logic [1:0]          rd_req_w;
  logic [1:0]          wr_req_w;
  logic [1:0]          req_w;
  logic [ADDR_LEN-1:0] addr_w    [2];
  logic [LINE_LEN-1:0] wr_data_w [2];
  logic [1:0]          rd_ready_w, rd_last_w, rd_error_w, wr_ready_w, wr_error_w;
  logic                winner;

  assign rd_req_w     = {d_port.rd_req, i_port.rd_req};
  assign wr_req_w     = {d_port.wr_req, i_port.wr_req};
  assign req_w        = rd_req_w | wr_req_w;
  assign addr_w[0]    = i_port.addr;
  assign addr_w[1]    = d_port.addr;
  assign wr_data_w[0] = i_port.wr_data;
  assign wr_data_w[1] = d_port.wr_data;

  // Grant phases are gated by rst_ni so every output drops the moment reset
  // asserts, even though the state register is cleared asynchronously.
  logic in_rd, in_wr;
  assign in_rd = rst_ni & (state_q == RD);
  assign in_wr = rst_ni & (state_q == WR);

  // State and arbitration history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      pair_valid_q <= 1'b0;
      pair_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      pair_valid_q <= pair_valid_d;
      pair_owner_q <= pair_owner_d;
    end
  end

  // Arbitration decision in IDLE and end-of-transaction detection.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    pair_valid_d = pair_valid_q;
    pair_owner_d = pair_owner_q;
    winner       = 1'b0;
    if (req_w == 2'b10) begin
      winner = 1'b1;
    end else if (req_w == 2'b11) begin
      winner = pair_valid_q ? pair_owner_q : ~last_owner_q;
    end
    case (state_q)
      IDLE: begin
        if (|req_w) begin
          owner_d      = winner;
          last_owner_d = winner;
          pair_valid_d = 1'b0;
          // A master raising both requests gets its write first.
          state_d      = wr_req_w[winner] ? WR : RD;
        end
      end
      RD: begin
        if (mem_port.rd_ready && mem_port.rd_last) begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (mem_port.wr_ready) begin
          state_d      = IDLE;
          pair_valid_d = 1'b1;
          pair_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream request mux: follows the owner's live request lines.
  always_comb begin
    mem_port.addr    = '0;
    mem_port.rd_req  = 1'b0;
    mem_port.wr_req  = 1'b0;
    mem_port.wr_data = '0;
    if (in_rd) begin
      mem_port.addr   = addr_w[owner_q];
      mem_port.rd_req = rd_req_w[owner_q];
    end
    if (in_wr) begin
      mem_port.addr    = addr_w[owner_q];
      mem_port.wr_req  = wr_req_w[owner_q];
      mem_port.wr_data = wr_data_w[owner_q];
    end
  end

  // Zero-latency response routing: only the owner sees handshake strobes.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      logic sel;
      assign sel            = (owner_q == 1'(gi));
      assign rd_ready_w[gi] = in_rd & sel & mem_port.rd_ready;
      assign rd_last_w[gi]  = in_rd & sel & mem_port.rd_last;
      assign rd_error_w[gi] = in_rd & sel & mem_port.rd_error;
      assign wr_ready_w[gi] = in_wr & sel & mem_port.wr_ready;
      assign wr_error_w[gi] = in_wr & sel & mem_port.wr_error;
    end
  endgenerate

  assign i_port.rd_ready = rd_ready_w[0];
  assign i_port.rd_last  = rd_last_w[0];
  assign i_port.rd_error = rd_error_w[0];
  assign i_port.wr_ready = wr_ready_w[0];
  assign i_port.wr_error = wr_error_w[0];
  assign d_port.rd_ready = rd_ready_w[1];
  assign d_port.rd_last  = rd_last_w[1];
  assign d_port.rd_error = rd_error_w[1];
  assign d_port.wr_ready = wr_ready_w[1];
  assign d_port.wr_error = wr_error_w[1];

  // Beat data is broadcast; consumers qualify it with rd_ready.
  assign i_port.rd_data = rst_ni ? mem_port.rd_data : 64'd0;
  assign d_port.rd_data = rst_ni ? mem_port.rd_data : 64'd0;

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Bench for the I/D cache-line arbiter: a cycle table of directed scenarios
// followed by randomized traffic checked against a transaction-level model.
module tb_ysyx_040066_mem_arbiter;
  localparam int LL = 512;
  localparam int AL = 32;

  localparam logic [31:0] IA  = 32'h8000_0040;
  localparam logic [31:0] DA1 = 32'h8000_1000;
  localparam logic [31:0] DA2 = 32'h8000_2000;

  // Request nibble {i_rd, i_wr, d_rd, d_wr}
  localparam logic [3:0] NR = 4'b0000, IR = 4'b1000, IW = 4'b0100, DR = 4'b0010, DW = 4'b0001;
  // Memory response {rd_ready, rd_last, rd_error, wr_ready, wr_error}
  localparam logic [4:0] NONE = 5'b00000, BEAT = 5'b10000, LASTB = 5'b11000, EBEAT = 5'b10100,
                         WRDY = 5'b00010, WRDYE = 5'b00011;
  // Expected {mem_rd_req, mem_wr_req}
  localparam logic [1:0] NQ = 2'b00, RQ = 2'b10, WQ = 2'b01;
  // Expected {i_rd_ready,i_rd_last,i_rd_error,i_wr_ready,i_wr_error, d_...same}
  localparam logic [9:0] Z = 10'b0, IRD = 10'b10000_00000, ILAST = 10'b11000_00000,
                         IRERR = 10'b10100_00000, IWR = 10'b00010_00000,
                         DRD = 10'b00000_10000, DLAST = 10'b00000_11000,
                         DWR = 10'b00000_00010, DWRE = 10'b00000_00011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_040066_mem_arbiter_if #(.LINE_LEN(LL), .ADDR_LEN(AL)) i_if ();
  ysyx_040066_mem_arbiter_if #(.LINE_LEN(LL), .ADDR_LEN(AL)) d_if ();
  ysyx_040066_mem_arbiter_if #(.LINE_LEN(LL), .ADDR_LEN(AL)) m_if ();

  ysyx_040066_mem_arbiter #(.LINE_LEN(LL), .ADDR_LEN(AL)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .i_port  (i_if),
    .d_port  (d_if),
    .mem_port(m_if)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] da;
    logic [4:0]  mm;
    logic [1:0]  sel;   // 0 none, 1 I, 2 D drives mem_addr
    logic [1:0]  eq;
    logic [9:0]  eo;
  } vec_t;

  vec_t vecs [80];
  int   nv = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] da,
                     input logic [4:0] mm, input logic [1:0] sel,
                     input logic [1:0] eq, input logic [9:0] eo);
    vecs[nv].rst = r; vecs[nv].rq = rq; vecs[nv].da = da; vecs[nv].mm = mm;
    vecs[nv].sel = sel; vecs[nv].eq = eq; vecs[nv].eo = eo;
    nv++;
  endtask

  task automatic chk(input string name, input logic [LL-1:0] act, input logic [LL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] resp_bits();
    return {i_if.rd_ready, i_if.rd_last, i_if.rd_error, i_if.wr_ready, i_if.wr_error,
            d_if.rd_ready, d_if.rd_last, d_if.rd_error, d_if.wr_ready, d_if.wr_error};
  endfunction

  logic [LL-1:0] iwd, dwd;

  // Random-phase master, model and memory state
  bit            pend [2];
  bit            pend_wr [2];
  bit            done_prev [2];
  logic [31:0]   paddr [2];
  logic [LL-1:0] pdata [2];
  bit            busy;
  int            cur;
  bit            cur_wr;
  bit            pair_v;
  int            pair_o;
  int            last_g;
  int            beats_left;

  task automatic drive_masters();
    i_if.addr = paddr[0]; i_if.wr_data = pdata[0];
    i_if.rd_req = pend[0] & ~pend_wr[0]; i_if.wr_req = pend[0] & pend_wr[0];
    d_if.addr = paddr[1]; d_if.wr_data = pdata[1];
    d_if.rd_req = pend[1] & ~pend_wr[1]; d_if.wr_req = pend[1] & pend_wr[1];
  endtask

  initial begin
    iwd = {16{32'h1111_0000}};
    dwd = {16{32'hDDDD_5555}};
    i_if.addr = IA; i_if.wr_data = iwd; i_if.rd_req = 0; i_if.wr_req = 0;
    d_if.addr = DA1; d_if.wr_data = dwd; d_if.rd_req = 0; d_if.wr_req = 0;
    m_if.rd_ready = 0; m_if.rd_last = 0; m_if.rd_error = 0; m_if.rd_data = 64'd0;
    m_if.wr_ready = 0; m_if.wr_error = 0;

    // Single read burst, error on one beat
    add(0, NR, DA1, NONE, 0, NQ, Z);
    add(1, IR, DA1, NONE, 0, NQ, Z);
    add(1, IR, DA1, NONE, 1, RQ, Z);
    add(1, IR, DA1, NONE, 1, RQ, Z);
    for (int b = 0; b < 7; b++)
      add(1, IR, DA1, (b == 4) ? EBEAT : BEAT, 1, RQ, (b == 4) ? IRERR : IRD);
    add(1, IR, DA1, LASTB, 1, RQ, ILAST);
    add(1, NR, DA1, NONE, 0, NQ, Z);
    // Tie after reset goes to D, then alternation with a second tie
    add(0, NR, DA1, NONE, 0, NQ, Z);
    add(1, IR | DR, DA1, NONE, 0, NQ, Z);
    add(1, IR | DR, DA1, NONE, 2, RQ, Z);
    add(1, IR | DR, DA1, BEAT, 2, RQ, DRD);
    add(1, IR | DR, DA1, LASTB, 2, RQ, DLAST);
    add(1, IR, DA1, NONE, 0, NQ, Z);
    add(1, IR, DA1, NONE, 1, RQ, Z);
    add(1, IR, DA1, LASTB, 1, RQ, ILAST);
    add(1, IR | DR, DA1, NONE, 0, NQ, Z);
    add(1, IR | DR, DA1, NONE, 2, RQ, Z);
    add(1, IR | DR, DA1, LASTB, 2, RQ, DLAST);
    add(1, IR, DA1, NONE, 0, NQ, Z);
    add(1, IR, DA1, NONE, 1, RQ, Z);
    add(1, IR, DA1, LASTB, 1, RQ, ILAST);
    add(1, NR, DA1, NONE, 0, NQ, Z);
    // D eviction with write error, then paired refill beats pending I
    add(1, DW, DA1, NONE, 0, NQ, Z);
    add(1, DW, DA1, NONE, 2, WQ, Z);
    add(1, DW, DA1, WRDYE, 2, WQ, DWRE);
    add(1, IR | DR, DA2, NONE, 0, NQ, Z);
    add(1, IR | DR, DA2, NONE, 2, RQ, Z);
    add(1, IR | DR, DA2, LASTB, 2, RQ, DLAST);
    add(1, IR, DA2, NONE, 0, NQ, Z);
    add(1, IR, DA2, NONE, 1, RQ, Z);
    add(1, IR, DA2, LASTB, 1, RQ, ILAST);
    add(1, NR, DA2, NONE, 0, NQ, Z);
    // I write pairs with its read; the pair then expires and D wins next tie
    add(1, IW, DA2, NONE, 0, NQ, Z);
    add(1, IW, DA2, NONE, 1, WQ, Z);
    add(1, IW, DA2, WRDY, 1, WQ, IWR);
    add(1, IR | DR, DA2, NONE, 0, NQ, Z);
    add(1, IR | DR, DA2, NONE, 1, RQ, Z);
    add(1, IR | DR, DA2, LASTB, 1, RQ, ILAST);
    add(1, IR | DR, DA2, NONE, 0, NQ, Z);
    add(1, IR | DR, DA2, NONE, 2, RQ, Z);
    add(1, IR | DR, DA2, LASTB, 2, RQ, DLAST);
    add(1, IR, DA2, NONE, 0, NQ, Z);
    add(1, IR, DA2, NONE, 1, RQ, Z);
    add(1, IR, DA2, LASTB, 1, RQ, ILAST);
    add(1, NR, DA2, NONE, 0, NQ, Z);
    // Write wins when one master raises both requests
    add(1, DR | DW, DA1, NONE, 0, NQ, Z);
    add(1, DR | DW, DA1, NONE, 2, WQ, Z);
    add(1, DR | DW, DA1, WRDY, 2, WQ, DWR);
    add(1, DR, DA1, NONE, 0, NQ, Z);
    add(1, DR, DA1, NONE, 2, RQ, Z);
    add(1, DR, DA1, LASTB, 2, RQ, DLAST);
    add(1, NR, DA1, NONE, 0, NQ, Z);
    // Reset at beat 4 of a burst; beats keep arriving but are dropped
    add(1, IR, DA1, NONE, 0, NQ, Z);
    add(1, IR, DA1, NONE, 1, RQ, Z);
    for (int b = 0; b < 3; b++) add(1, IR, DA1, BEAT, 1, RQ, IRD);
    add(0, IR, DA1, BEAT, 0, NQ, Z);
    add(0, IR, DA1, BEAT, 0, NQ, Z);
    add(1, IR | DR, DA1, NONE, 0, NQ, Z);
    add(1, IR | DR, DA1, NONE, 2, RQ, Z);
    add(1, IR | DR, DA1, LASTB, 2, RQ, DLAST);
    add(1, IR, DA1, NONE, 0, NQ, Z);
    add(1, IR, DA1, NONE, 1, RQ, Z);
    add(1, IR, DA1, LASTB, 1, RQ, ILAST);
    add(1, NR, DA1, NONE, 0, NQ, Z);

    repeat (2) @(posedge clk);

    for (int k = 0; k < nv; k++) begin
      logic [63:0] rdat;
      @(posedge clk); #1;
      rst_n = vecs[k].rst;
      {i_if.rd_req, i_if.wr_req, d_if.rd_req, d_if.wr_req} = vecs[k].rq;
      d_if.addr = vecs[k].da;
      {m_if.rd_ready, m_if.rd_last, m_if.rd_error, m_if.wr_ready, m_if.wr_error} = vecs[k].mm;
      rdat = {$urandom, $urandom};
      m_if.rd_data = rdat;
      #3;
      chk($sformatf("row%0d mem_rd_req", k), m_if.rd_req, vecs[k].eq[1]);
      chk($sformatf("row%0d mem_wr_req", k), m_if.wr_req, vecs[k].eq[0]);
      chk($sformatf("row%0d resp", k), resp_bits(), vecs[k].eo);
      chk($sformatf("row%0d i_rd_data", k), i_if.rd_data, vecs[k].rst ? rdat : 64'd0);
      chk($sformatf("row%0d d_rd_data", k), d_if.rd_data, vecs[k].rst ? rdat : 64'd0);
      if (!vecs[k].rst) begin
        chk($sformatf("row%0d mem_addr_rst", k), m_if.addr, 32'd0);
        chk($sformatf("row%0d mem_wr_data_rst", k), m_if.wr_data, '0);
      end else if (vecs[k].sel != 0) begin
        chk($sformatf("row%0d mem_addr", k), m_if.addr, (vecs[k].sel == 1) ? IA : vecs[k].da);
      end
      if (vecs[k].eq[0])
        chk($sformatf("row%0d mem_wr_data", k), m_if.wr_data, (vecs[k].sel == 1) ? iwd : dwd);
      $display("row %0d rst=%0b req=%b mem=%b rd_req=%0b wr_req=%0b resp=%b",
               k, vecs[k].rst, vecs[k].rq, vecs[k].mm, m_if.rd_req, m_if.wr_req, resp_bits());
    end

    // Randomized traffic against a transaction-level model
    @(posedge clk); #1;
    rst_n = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; pend_wr[m] = 0; done_prev[m] = 0; paddr[m] = 32'd0; pdata[m] = '0;
    end
    drive_masters();
    m_if.rd_ready = 0; m_if.rd_last = 0; m_if.rd_error = 0; m_if.wr_ready = 0; m_if.wr_error = 0;
    busy = 0; cur = 0; cur_wr = 0; pair_v = 0; pair_o = 0; last_g = 0; beats_left = 0;
    @(posedge clk); #1;
    rst_n = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit            exp_rreq, exp_wreq, hs;
      logic [4:0]    exp_r [2];
      logic [4:0]    act_r [2];
      @(posedge clk); #1;
      // Masters: retire finished transactions, maybe issue new ones
      for (int m = 0; m < 2; m++) begin
        if (done_prev[m]) begin
          if (pend_wr[m] && $urandom_range(0, 1) == 1) begin
            pend_wr[m] = 0;  // refill right after the eviction
            paddr[m] = $urandom & 32'hFFFF_FFC0;
          end else begin
            pend[m] = 0;
          end
          done_prev[m] = 0;
        end else if (!pend[m] && $urandom_range(0, 3) == 0) begin
          pend[m] = 1;
          pend_wr[m] = ($urandom_range(0, 2) == 0);
          paddr[m] = $urandom & 32'hFFFF_FFC0;
          for (int w = 0; w < LL / 32; w++) pdata[m][w*32 +: 32] = $urandom;
        end
      end
      drive_masters();
      #1;
      // Memory responder reacting to the downstream request
      m_if.rd_ready = 0; m_if.rd_last = 0; m_if.rd_error = 0; m_if.wr_ready = 0; m_if.wr_error = 0;
      m_if.rd_data = {$urandom, $urandom};
      if (m_if.rd_req) begin
        if (beats_left == 0) beats_left = $urandom_range(1, 8);
        if ($urandom_range(0, 3) != 0) begin
          m_if.rd_ready = 1;
          m_if.rd_last = (beats_left == 1);
          m_if.rd_error = ($urandom_range(0, 7) == 0);
          beats_left--;
        end
      end else if (m_if.wr_req) begin
        if ($urandom_range(0, 2) == 0) begin
          m_if.wr_ready = 1;
          m_if.wr_error = ($urandom_range(0, 3) == 0);
        end
      end
      #1;
      // Expected outputs from the model's view of the current transaction
      exp_rreq = busy && !cur_wr && pend[cur] && !pend_wr[cur];
      exp_wreq = busy && cur_wr && pend[cur] && pend_wr[cur];
      chk($sformatf("rnd%0d mem_rd_req", cyc), m_if.rd_req, exp_rreq);
      chk($sformatf("rnd%0d mem_wr_req", cyc), m_if.wr_req, exp_wreq);
      if (busy) chk($sformatf("rnd%0d mem_addr", cyc), m_if.addr, paddr[cur]);
      if (exp_wreq) chk($sformatf("rnd%0d mem_wr_data", cyc), m_if.wr_data, pdata[cur]);
      for (int m = 0; m < 2; m++) begin
        bit own_rd, own_wr;
        own_rd = busy && cur == m && !cur_wr;
        own_wr = busy && cur == m && cur_wr;
        exp_r[m] = {own_rd & m_if.rd_ready, own_rd & m_if.rd_last, own_rd & m_if.rd_error,
                    own_wr & m_if.wr_ready, own_wr & m_if.wr_error};
      end
      act_r[0] = {i_if.rd_ready, i_if.rd_last, i_if.rd_error, i_if.wr_ready, i_if.wr_error};
      act_r[1] = {d_if.rd_ready, d_if.rd_last, d_if.rd_error, d_if.wr_ready, d_if.wr_error};
      chk($sformatf("rnd%0d i_resp", cyc), act_r[0], exp_r[0]);
      chk($sformatf("rnd%0d d_resp", cyc), act_r[1], exp_r[1]);
      chk($sformatf("rnd%0d d_rd_data", cyc), d_if.rd_data, m_if.rd_data);
      $display("rnd %0d busy=%0b owner=%0d wr=%0b rd_req=%0b wr_req=%0b i=%b d=%b",
               cyc, busy, cur, cur_wr, m_if.rd_req, m_if.wr_req, act_r[0], act_r[1]);
      // Advance the model by one cycle
      hs = busy && (cur_wr ? m_if.wr_ready : (m_if.rd_ready && m_if.rd_last));
      if (busy) begin
        if (hs) begin
          done_prev[cur] = 1;
          busy = 0;
          if (cur_wr) begin
            pair_v = 1;
            pair_o = cur;
          end
        end
      end else if (pend[0] || pend[1]) begin
        int w;
        if (pend[0] && pend[1]) w = pair_v ? pair_o : 1 - last_g;
        else w = pend[1] ? 1 : 0;
        busy = 1; cur = w; cur_wr = pend_wr[w]; last_g = w; pair_v = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
